hash_state_bank: RTL and testbench
==================================

// Module: hash_state_bank
// PURPOSE
//  Parametrised hash-state register bank for the SHA-256 mining datapath.
//  Holds NUM_WORDS chaining words, reloads them from the IV, and adds compression results back word-serially (mod 2^WORD_W).
//  Runs a word-serial ones-count over the whole state.
//  Sits between the message scheduler/compression core and the nonce-check logic.
// PARAMETERS
//  WORD_W     32                      width of one state word
//  NUM_WORDS  8                       number of state words (H0..H7)
//  IV_VEC     SHA-256 H0..H7          NUM_WORDS*WORD_W initial value; word k at bits [k*WORD_W +: WORD_W]
//  CNT_W      $clog2(NUM_WORDS*WORD_W+1)  ones-count width (9 for defaults)
// PORTS
//  clk         in   1                       rising-edge clock
//  rst_n       in   1                       asynchronous active-low reset
//  start       in   1                       begin operation selected by op; sampled only in IDLE
//  op          in   2                       00 INIT, 01 ACCUM, 10 POPCOUNT, 11 reserved
//  acc_in      in   WORD_W                  word to add to H[idx] in ACCUM
//  acc_valid   in   1                       acc_in valid
//  acc_ready   out  1                       bank accepts acc_in this cycle
//  rd_addr     in   $clog2(NUM_WORDS)       read address
//  rd_data     out  WORD_W                  registered read data
//  busy        out  1                       operation in progress
//  done        out  1                       one-cycle completion pulse
//  ones_count  out  CNT_W                   result of last POPCOUNT
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - H[k] = IV word k; state IDLE; idx=0.
//   - busy, done, acc_ready, rd_data and ones_count all 0.
//   - Reset mid-operation aborts the operation; the bank returns to IV and no done pulse is produced.
//  States: IDLE, INIT, ACCUM, POPCNT, DONE. busy = (state != IDLE).
//  IDLE: start=1 at edge T selects the next state by op, with idx=0 and busy=1 from T+1.
//   - op=11 is ignored: the bank stays IDLE with no busy and no done.
//   - start is ignored in every other state.
//  INIT:
//   - Cycle T+1+k writes H[k] = IV word k, for k = 0..NUM_WORDS-1.
//   - After the last write the state goes to DONE; done=1 at T+1+NUM_WORDS.
//  ACCUM:
//   - acc_ready=1 throughout the state.
//   - On each acc_valid&&acc_ready: H[idx] <= (H[idx]+acc_in) mod 2^WORD_W; carry out is discarded; idx++.
//   - acc_valid=0 stalls with no state change and no timeout.
//   - After the handshake for idx=NUM_WORDS-1 the state goes to DONE; acc_ready=0 in DONE.
//  POPCNT:
//   - ones_count is cleared at entry.
//   - Each cycle adds popcount(H[idx]); idx++.
//   - Runs NUM_WORDS cycles, then DONE.
//   - ones_count holds its value until the next POPCOUNT or reset; it is valid when done=1.
//  DONE: done=1 for exactly one cycle, then IDLE. A start asserted during DONE is ignored.
//  Read port:
//   - rd_data <= H[rd_addr] every cycle; 1-cycle latency in every state.
//   - Same-cycle write to the addressed word returns the old value.
//   - rd_addr >= NUM_WORDS returns 0.
//  Arithmetic: all adds unsigned. The ones-count accumulator is CNT_W wide and cannot overflow.
// TESTING
//  1. Reset, then read addr 0..7 -> 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
//  2. Reset, POPCOUNT -> busy for 9 cycles (8 POPCNT cycles + DONE), single done pulse, ones_count=136 (0x088).
//  3. ACCUM with acc_in=ffffffff for all 8 words -> H0=6a09e666, H7=5be0cd18; done one cycle after the 8th handshake.
//  4. ACCUM word 1 with acc_in=4498517b, others 0 -> H1=00000000 (wrap); then POPCOUNT -> 117.
//  5. ACCUM with acc_valid toggled randomly, plus start and op=11 pulses mid-op -> same result as test 3; extra starts and op=11 ignored.
//  6. Assert rst_n=0 mid-ACCUM after 3 words -> H back to IV, busy=0, no done; then INIT -> done after 8 writes.

Source files
------------

// File: rtl/hash_state_bank.sv
`default_nettype none
// ============================================================================
// Module   : hash_state_bank
// Brief    : SHA-256 chaining-state bank with IV reload, word-serial
//            accumulate and word-serial ones-count.
// Revision : 1.0
// ============================================================================
module hash_state_bank #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter logic [NUM_WORDS*WORD_W-1:0] IV_VEC = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667},
  parameter int CNT_W     = $clog2(NUM_WORDS*WORD_W+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic [WORD_W-1:0]            acc_in,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic [$clog2(NUM_WORDS)-1:0] rd_addr,
  output logic [WORD_W-1:0]            rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             ones_count
);

  localparam int c_aw = $clog2(NUM_WORDS);
  localparam logic [c_aw-1:0] c_last = c_aw'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ACCUM  = 3'd2,
    S_POPCNT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_aw-1:0]   r_idx;
  logic [WORD_W-1:0] r_h [NUM_WORDS];
  logic [WORD_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_done;
  logic              r_acc_ready;
  logic [CNT_W-1:0]  r_ones;

  logic [WORD_W-1:0] w_iv [NUM_WORDS];
  logic [WORD_W-1:0] w_rd_word;
  logic [CNT_W-1:0]  w_pop;

  generate
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_iv
      assign w_iv[k] = IV_VEC[k*WORD_W +: WORD_W];
    end
  endgenerate

  // Only a non-power-of-two bank can be addressed past its last word.
  generate
    if ((1 << c_aw) == NUM_WORDS) begin : g_rd_full
      assign w_rd_word = r_h[rd_addr];
    end else begin : g_rd_partial
      assign w_rd_word = (int'({1'b0, rd_addr}) < NUM_WORDS) ? r_h[rd_addr] : '0;
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_pop = w_pop + CNT_W'(r_h[r_idx][i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_ready <= 1'b0;
      r_ones      <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_h[k] <= IV_VEC[k*WORD_W +: WORD_W];
      end
    end else begin
      r_rd_data <= w_rd_word;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            case (op)
              2'b00: begin
                r_state <= S_INIT;
                r_busy  <= 1'b1;
              end
              2'b01: begin
                r_state     <= S_ACCUM;
                r_busy      <= 1'b1;
                r_acc_ready <= 1'b1;
              end
              2'b10: begin
                r_state <= S_POPCNT;
                r_busy  <= 1'b1;
                r_ones  <= '0;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_INIT: begin
          r_h[r_idx] <= w_iv[r_idx];
          r_idx      <= r_idx + 1'b1;
          if (r_idx == c_last) begin
            r_idx   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (acc_valid) begin
            r_h[r_idx] <= r_h[r_idx] + acc_in;
            r_idx      <= r_idx + 1'b1;
            if (r_idx == c_last) begin
              r_idx       <= '0;
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_acc_ready <= 1'b0;
            end
          end
        end
        S_POPCNT: begin
          r_ones <= r_ones + w_pop;
          r_idx  <= r_idx + 1'b1;
          if (r_idx == c_last) begin
            r_idx   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_acc_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign acc_ready  = r_acc_ready;
  assign ones_count = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_hash_state_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_state_bank
// Brief    : Randomised bench for hash_state_bank against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_hash_state_bank;

  localparam int N  = 8;
  localparam int CW = 9;
  localparam logic [31:0] IV_TAB [N] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [31:0]   acc_in;
  logic          acc_valid;
  logic          acc_ready;
  logic [2:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_count;

  hash_state_bank dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .ones_count(ones_count));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int busy_seen = 0;
  int done_seen = 0;
  logic [31:0] vals [N];

  // Model: mode 0 idle, 1 reload, 2 accumulate, 3 ones-count, 4 done pulse.
  int          m_mode;
  int          m_k;
  int          m_ones;
  logic [31:0] m_h [N];
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_h[k] = IV_TAB[k];
      m_mode = 0;
      m_k    = 0;
      m_ones = 0;
      m_rd   = 32'h0;
    end else begin
      m_rd = m_h[rd_addr];
      case (m_mode)
        0: if (start) begin
          m_k = 0;
          if (op == 2'd0) m_mode = 1;
          else if (op == 2'd1) m_mode = 2;
          else if (op == 2'd2) begin m_mode = 3; m_ones = 0; end
        end
        1: begin m_h[m_k] = IV_TAB[m_k]; m_k++; end
        2: if (acc_valid) begin m_h[m_k] = m_h[m_k] + acc_in; m_k++; end
        3: begin m_ones += $countones(m_h[m_k]); m_k++; end
        default: m_mode = 0;
      endcase
      if (m_k == N) begin
        m_k    = 0;
        m_mode = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_mode == 4));
      check("acc_ready", 32'(acc_ready), 32'(m_mode == 2));
      check("rd_data", rd_data, m_rd);
      check("ones_count", 32'(ones_count), 32'(m_ones));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic read_word(input logic [2:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    tick();
    check(name, rd_data, exp);
  endtask

  task automatic run_op(input logic [1:0] o, input bit rnd, input bit noise, output int cyc);
    cyc = 0;
    op = o;
    start = 1'b1;
    acc_valid = 1'b0;
    tick();
    start = 1'b0;
    if (o == 2'b11) begin
      repeat (4) tick();
      return;
    end
    for (int c = 1; c <= 200; c++) begin
      acc_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_in    = vals[m_k];
      rd_addr   = 3'($urandom_range(0, 7));
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom_range(0, 3));
      end
      tick();
      if (done) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen in 200 cycles for op %0d", o);
    end
    start = noise;
    op = 2'($urandom_range(0, 3));
    acc_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cyc, b0, d0;
    rst_n = 1'b1; start = 1'b0; op = 2'b00;
    acc_in = '0; acc_valid = 1'b0; rd_addr = '0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    for (int a = 0; a < N; a++) read_word(3'(a), IV_TAB[a], "iv_read");

    do_reset();
    b0 = busy_seen; d0 = done_seen;
    run_op(2'b10, 1'b0, 1'b0, cyc);
    check("pop_busy_cycles", 32'(busy_seen - b0), 32'd9);
    check("pop_done_pulses", 32'(done_seen - d0), 32'd1);
    check("pop_iv", 32'(ones_count), 32'd136);

    do_reset();
    for (int k = 0; k < N; k++) vals[k] = 32'hffffffff;
    run_op(2'b01, 1'b0, 1'b0, cyc);
    check("acc_latency", 32'(cyc), 32'd8);
    read_word(3'd0, 32'h6a09e666, "acc_ff_h0");
    read_word(3'd7, 32'h5be0cd18, "acc_ff_h7");

    do_reset();
    for (int k = 0; k < N; k++) vals[k] = 32'h0;
    vals[1] = 32'h4498517b;
    run_op(2'b01, 1'b0, 1'b0, cyc);
    read_word(3'd1, 32'h00000000, "acc_wrap_h1");
    run_op(2'b10, 1'b0, 1'b0, cyc);
    check("pop_after_wrap", 32'(ones_count), 32'd117);

    do_reset();
    for (int k = 0; k < N; k++) vals[k] = 32'hffffffff;
    d0 = done_seen;
    run_op(2'b01, 1'b1, 1'b1, cyc);
    check("noisy_done_pulses", 32'(done_seen - d0), 32'd1);
    read_word(3'd0, 32'h6a09e666, "noisy_h0");
    read_word(3'd7, 32'h5be0cd18, "noisy_h7");
    b0 = busy_seen; d0 = done_seen;
    run_op(2'b11, 1'b0, 1'b0, cyc);
    check("op11_busy", 32'(busy_seen - b0), 32'd0);
    check("op11_done", 32'(done_seen - d0), 32'd0);

    do_reset();
    for (int k = 0; k < N; k++) vals[k] = $urandom;
    d0 = done_seen;
    op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc_valid = 1'b1; acc_in = vals[k];
      tick();
    end
    acc_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    check("rst_no_done", 32'(done_seen - d0), 32'd0);
    for (int a = 0; a < N; a++) read_word(3'(a), IV_TAB[a], "rst_iv");
    d0 = done_seen;
    run_op(2'b00, 1'b0, 1'b0, cyc);
    check("init_latency", 32'(cyc), 32'd8);
    check("init_done_pulses", 32'(done_seen - d0), 32'd1);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < N; k++) vals[k] = $urandom;
      run_op(2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), cyc);
    end
    for (int a = 0; a < N; a++) begin
      rd_addr = 3'(a);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
